sync_fifo_arbiter: RTL and testbench
====================================

# sync_fifo_arbiter

Write-side scheduler that shares one shallow `sync_fifo` clock-domain crossing between several requesters in the same clock domain. It arbitrates round-robin among requesters and tags each accepted word with the requester index. It paces writes with a minimum inter-write gap and a credit counter that models the reader-side drain rate, so the 4-entry FIFO, which has no full flag on its write side, is never overrun.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8)
- `WIDTH`, 16: payload width per requester
- `CREDITS`, 4: max words in flight; equals FIFO depth
- `REFILL`, 8: write-clock cycles per returned credit (≥ worst-case reader drain time per entry)
- `GAP`, 1: idle cycles forced after each FIFO write (0 allowed)
- Derived: `TAG_W = max(1, clog2(NUM_REQ))`, `CW = clog2(CREDITS+1)`

Ports:
- `clk` in 1: single clock, the FIFO write clock
- `reset` in 1: synchronous, active-high
- `req_valid` in NUM_REQ: per-requester word available
- `req_data` in NUM_REQ*WIDTH: requester i occupies bits [i*WIDTH +: WIDTH]
- `req_ready` out NUM_REQ: one-hot accept; a transfer occurs when valid & ready in the same cycle
- `fifo_write_en` out 1: drives FIFO `write_en`
- `fifo_data` out TAG_W+WIDTH: `{tag, payload}`, drives FIFO `data_in`
- `credits_avail` out CW: current credit count
- `busy` out 1: high whenever the state is not IDLE

## Operation
- FSM states:
  - IDLE → ISSUE on accept.
  - ISSUE → GAP if GAP>0, else → IDLE.
  - GAP → IDLE after GAP cycles, counted by a gap counter.
- Accept only in IDLE with `credits_avail > 0` and at least one `req_valid`. `req_ready` is combinational from state, credits, valids and the round-robin pointer. At most one bit is set, never while `reset` is high.
- Round-robin: search starts at `(last_grant+1) mod NUM_REQ`. `last_grant` updates on accept. Reset value is NUM_REQ-1, so requester 0 has first priority.
- On accept, the tag and payload are registered. `fifo_write_en` is high for exactly the ISSUE cycle, and `fifo_data` holds the word that cycle. `fifo_data` keeps its last value otherwise.
- Requesters may drop `req_valid` without being accepted; no penalty.
- Credits:
  - Decrement on accept.
  - Refill timer increments each cycle credits < CREDITS and is held at 0 at full.
  - When the timer reaches REFILL-1: credits +1, timer → 0.
  - Accept and refill in the same cycle: count unchanged, timer still wraps to 0.
  - Credits never exceed CREDITS and never go below 0.
- Reset mid-operation: a registered word not yet written is dropped, state → IDLE, credits → CREDITS, timer → 0, pointer → NUM_REQ-1. The downstream FIFO is not reset by this block.

## Timing
- Reset values: `fifo_write_en` 0, `fifo_data` 0, `req_ready` 0, `credits_avail` CREDITS, `busy` 0.
- Latency: accept in cycle t → `fifo_write_en` in t+1.
- Maximum throughput: one word per 2+GAP cycles. Sustained rate is also limited to one word per REFILL cycles.
- `credits_avail` reflects accepts and refills one cycle after the triggering edge (registered).

## Structure
- Package `sync_fifo_arb_pkg`:
  - state enum `{IDLE, ISSUE, GAP}`
  - `clog2`-based TAG_W/CW helper functions
- Sub-module `rr_priority_pick`: combinational rotate-and-priority-encode. Inputs are the NUM_REQ request vector and the pointer; outputs are a one-hot grant and a valid flag. This keeps the FSM and credit logic in the top level.

## Test plan
Defaults unless stated.
- **Single word:** after reset, `req_valid[2]=1`, payload 16'hBEEF in cycle 0 → `req_ready=4'b0100` in cycle 0; `fifo_write_en=1` with `fifo_data=18'h2BEEF` in cycle 1; `credits_avail=3` from cycle 1.
- **Fairness:** all four valids held high → accepts at cycles 0,3,6,9 to requesters 0,1,2,3, then 0. Exactly one `req_ready` bit per accept; `fifo_write_en` in cycles 1,4,7,10.
- **Credit starvation (REFILL=32):** all valid → accepts at 0,3,6,9. Credits reach 0 in cycle 10; no accept until credits=1 in cycle 33; accept in cycle 33.
- **Simultaneous accept and refill:** with REFILL=8, single requester valid at cycles 0 and 8 (credit refill lands at the end of cycle 8) → `credits_avail` stays 3 across cycle 9; timer restarts at 0.
- **GAP=0:** two requesters valid continuously → accepts every 2 cycles, alternating, until credits are exhausted.
- **Reset mid-operation:** reset asserted during the ISSUE cycle → `fifo_write_en=0` and `credits_avail=4` next cycle. The first post-reset accept goes to requester 0 even if requester 1 was next.

Source files
------------

// File: rtl/sync_fifo_arb_pkg.sv
// Shared types and width helpers for the sync_fifo write-side arbiter.
package sync_fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP
  } arb_state_t;

  function automatic int tag_width(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

  function automatic int credit_width(input int credits);
    return $clog2(credits + 1);
  endfunction

  // Width of a counter that runs 0..n-1, never narrower than one bit.
  function automatic int count_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first asserted request strictly after the pointer,
// wrapping around, returned as a one-hot grant.
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  always_comb begin
    logic [PTR_W-1:0] sel;
    grant = '0;
    valid = 1'b0;
    sel   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sel = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (!valid && req[sel]) begin
        grant[sel] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sync_fifo_arbiter.sv
// Round-robin write scheduler for a shallow sync_fifo: tags each word with
// its requester and paces writes with a gap counter and a drain-rate credit model.
module sync_fifo_arbiter
  import sync_fifo_arb_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  parameter int  WIDTH   = 16,
  parameter int  CREDITS = 4,
  parameter int  REFILL  = 8,
  parameter int  GAP     = 1,
  localparam int TAG_W   = tag_width(NUM_REQ),
  localparam int CW      = credit_width(CREDITS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     fifo_write_en,
  output logic [TAG_W+WIDTH-1:0]   fifo_data,
  output logic [CW-1:0]            credits_avail,
  output logic                     busy
);

  localparam int             RW          = count_width(REFILL);
  localparam int             GW          = count_width(GAP);
  localparam logic [CW-1:0]  CRED_FULL   = CW'(CREDITS);
  localparam logic [RW-1:0]  REFILL_LAST = RW'(REFILL - 1);
  localparam logic [GW-1:0]  GAP_LAST    = GW'((GAP > 0) ? GAP - 1 : 0);

  arb_state_t             state_q, state_d;
  logic [GW-1:0]          gap_cnt_q, gap_cnt_d;
  logic [TAG_W-1:0]       last_q, last_d;
  logic [CW-1:0]          credits_q, credits_d;
  logic [RW-1:0]          timer_q, timer_d;
  logic [TAG_W+WIDTH-1:0] word_q, word_d;

  logic [NUM_REQ-1:0]     grant;
  logic                   grant_valid;
  logic                   accept;
  logic                   refill;
  logic [TAG_W-1:0]       grant_idx;
  logic [WIDTH-1:0]       grant_payload;

  rr_priority_pick #(
    .NUM_REQ(NUM_REQ),
    .PTR_W  (TAG_W)
  ) u_pick (
    .req  (req_valid),
    .ptr  (last_q),
    .grant(grant),
    .valid(grant_valid)
  );

  always_comb begin
    grant_idx     = '0;
    grant_payload = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx     = TAG_W'(i);
        grant_payload = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Gating with reset keeps req_ready silent while the block is being cleared.
  assign accept    = !reset && (state_q == ST_IDLE) && (credits_q != '0) && grant_valid;
  assign refill    = (credits_q != CRED_FULL) && (timer_q == REFILL_LAST);
  assign req_ready = accept ? grant : '0;

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    last_d    = last_q;
    word_d    = word_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ISSUE;
          last_d  = grant_idx;
          word_d  = {grant_idx, grant_payload};
        end
      end
      ST_ISSUE: begin
        gap_cnt_d = '0;
        state_d   = (GAP > 0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
        else                       gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A same-cycle accept and refill cancel; the timer wraps regardless.
  always_comb begin
    credits_d = credits_q;
    if (credits_q == CRED_FULL) timer_d = '0;
    else if (refill)            timer_d = '0;
    else                        timer_d = timer_q + 1'b1;
    case ({accept, refill})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01:   credits_d = credits_q + 1'b1;
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gap_cnt_q <= '0;
      last_q    <= TAG_W'(NUM_REQ - 1);
      credits_q <= CRED_FULL;
      timer_q   <= '0;
      word_q    <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      last_q    <= last_d;
      credits_q <= credits_d;
      timer_q   <= timer_d;
      word_q    <= word_d;
    end
  end

  assign fifo_write_en = (state_q == ST_ISSUE);
  assign fifo_data     = word_q;
  assign credits_avail = credits_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sync_fifo_arbiter.sv
// Directed bench: a vector table on the default build plus hand-written
// sequences on slow-refill and zero-gap builds sharing the same stimulus.
module tb_sync_fifo_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [63:0] req_data;

  logic [3:0]  ready_def, ready_slow, ready_fast;
  logic        we_def, we_slow, we_fast;
  logic [17:0] data_def, data_slow, data_fast;
  logic [2:0]  cred_def, cred_slow, cred_fast;
  logic        busy_def, busy_slow, busy_fast;

  int check_count = 0;
  int pass_count  = 0;

  sync_fifo_arbiter u_def (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready_def), .fifo_write_en(we_def), .fifo_data(data_def),
    .credits_avail(cred_def), .busy(busy_def)
  );

  sync_fifo_arbiter #(.REFILL(32)) u_slow (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready_slow), .fifo_write_en(we_slow), .fifo_data(data_slow),
    .credits_avail(cred_slow), .busy(busy_slow)
  );

  sync_fifo_arbiter #(.GAP(0)) u_fast (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready_fast), .fifo_write_en(we_fast), .fifo_data(data_fast),
    .credits_avail(cred_fast), .busy(busy_fast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  ready;
    logic        we;
    logic [17:0] data;
    logic [2:0]  cred;
    logic        busy;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [3:0] valid);
    req_valid = valid;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at the start of cycle 0: the last sampled reset was high.
  task automatic doReset();
    reset     = 1'b1;
    req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_r;

    req_data  = {16'h3333, 16'hBEEF, 16'h1111, 16'h1000};
    reset     = 1'b1;
    req_valid = 4'b1111;

    vecs[0]  = '{4'b0100, 4'b0100, 1'b0, 18'h00000, 3'd4, 1'b0};
    vecs[1]  = '{4'b0000, 4'b0000, 1'b1, 18'h2BEEF, 3'd3, 1'b1};
    vecs[2]  = '{4'b0000, 4'b0000, 1'b0, 18'h2BEEF, 3'd3, 1'b1};
    vecs[3]  = '{4'b1111, 4'b1000, 1'b0, 18'h2BEEF, 3'd3, 1'b0};
    vecs[4]  = '{4'b1111, 4'b0000, 1'b1, 18'h33333, 3'd2, 1'b1};
    vecs[5]  = '{4'b1111, 4'b0000, 1'b0, 18'h33333, 3'd2, 1'b1};
    vecs[6]  = '{4'b1111, 4'b0001, 1'b0, 18'h33333, 3'd2, 1'b0};
    vecs[7]  = '{4'b1111, 4'b0000, 1'b1, 18'h01000, 3'd1, 1'b1};
    vecs[8]  = '{4'b1111, 4'b0000, 1'b0, 18'h01000, 3'd1, 1'b1};
    vecs[9]  = '{4'b1111, 4'b0010, 1'b0, 18'h01000, 3'd2, 1'b0};
    vecs[10] = '{4'b1111, 4'b0000, 1'b1, 18'h11111, 3'd1, 1'b1};
    vecs[11] = '{4'b1111, 4'b0000, 1'b0, 18'h11111, 3'd1, 1'b1};
    vecs[12] = '{4'b0000, 4'b0000, 1'b0, 18'h11111, 3'd1, 1'b0};
    vecs[13] = '{4'b0000, 4'b0000, 1'b0, 18'h11111, 3'd1, 1'b0};

    $display("[TB] reset values, valids high during reset");
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready", ready_def, 4'b0000);
    checkOutput("reset_we",    we_def,    1'b0);
    checkOutput("reset_data",  data_def,  18'h0);
    checkOutput("reset_cred",  cred_def,  3'd4);
    checkOutput("reset_busy",  busy_def,  1'b0);

    $display("[TB] vector table: single word, rotation, refill, dropped valid");
    doReset();
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].valid);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_ready", i), ready_def, vecs[i].ready);
      checkOutput($sformatf("vec%0d_we", i),    we_def,    vecs[i].we);
      checkOutput($sformatf("vec%0d_data", i),  data_def,  vecs[i].data);
      checkOutput($sformatf("vec%0d_cred", i),  cred_def,  vecs[i].cred);
      checkOutput($sformatf("vec%0d_busy", i),  busy_def,  vecs[i].busy);
      nextCycle();
    end

    $display("[TB] fairness (REFILL=8) and credit starvation (REFILL=32)");
    doReset();
    for (int c = 0; c <= 34; c++) begin
      applyStimulus(4'b1111);
      @(negedge clk);
      if (c <= 13) begin
        case (c)
          0, 12:   exp_r = 4'b0001;
          3:       exp_r = 4'b0010;
          6:       exp_r = 4'b0100;
          9:       exp_r = 4'b1000;
          default: exp_r = 4'b0000;
        endcase
        checkOutput($sformatf("fair_ready_c%0d", c), ready_def, exp_r);
        checkOutput($sformatf("fair_we_c%0d", c), we_def,
                    (c == 1 || c == 4 || c == 7 || c == 10 || c == 13));
      end
      case (c)
        0, 33:   exp_r = 4'b0001;
        3:       exp_r = 4'b0010;
        6:       exp_r = 4'b0100;
        9:       exp_r = 4'b1000;
        default: exp_r = 4'b0000;
      endcase
      checkOutput($sformatf("starve_ready_c%0d", c), ready_slow, exp_r);
      if (c == 10 || c == 32 || c == 34) checkOutput($sformatf("starve_cred_c%0d", c), cred_slow, 3'd0);
      if (c == 33) checkOutput("starve_cred_c33", cred_slow, 3'd1);
      nextCycle();
    end

    $display("[TB] GAP=0 with two requesters");
    doReset();
    for (int c = 0; c <= 9; c++) begin
      applyStimulus(4'b0011);
      @(negedge clk);
      case (c)
        0, 4, 9: exp_r = 4'b0001;
        2, 6:    exp_r = 4'b0010;
        default: exp_r = 4'b0000;
      endcase
      checkOutput($sformatf("gap0_ready_c%0d", c), ready_fast, exp_r);
      checkOutput($sformatf("gap0_we_c%0d", c), we_fast, (c == 1 || c == 3 || c == 5 || c == 7));
      if (c == 8) checkOutput("gap0_cred_c8", cred_fast, 3'd0);
      if (c == 9) checkOutput("gap0_cred_c9", cred_fast, 3'd1);
      nextCycle();
    end

    $display("[TB] accept coinciding with refill");
    doReset();
    for (int c = 0; c <= 17; c++) begin
      applyStimulus((c == 0 || c == 8) ? 4'b0100 : 4'b0000);
      @(negedge clk);
      if (c == 8) checkOutput("coinc_ready_c8", ready_def, 4'b0100);
      if (c == 8 || c == 9 || c == 10 || c == 16)
        checkOutput($sformatf("coinc_cred_c%0d", c), cred_def, 3'd3);
      if (c == 17) checkOutput("coinc_cred_c17", cred_def, 3'd4);
      nextCycle();
    end

    $display("[TB] reset during ISSUE");
    doReset();
    applyStimulus(4'b0001);
    @(negedge clk);
    checkOutput("midrst_accept", ready_def, 4'b0001);
    nextCycle();
    applyStimulus(4'b0000);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_issue_we", we_def, 1'b1);
    nextCycle();
    reset = 1'b0;
    applyStimulus(4'b0011);
    @(negedge clk);
    checkOutput("midrst_we",    we_def,    1'b0);
    checkOutput("midrst_cred",  cred_def,  3'd4);
    checkOutput("midrst_data",  data_def,  18'h0);
    checkOutput("midrst_busy",  busy_def,  1'b0);
    checkOutput("midrst_ready", ready_def, 4'b0001);
    nextCycle();
    applyStimulus(4'b0000);
    @(negedge clk);
    checkOutput("midrst_word", data_def, 18'h01000);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
